if_fetch_stage: RTL and testbench

//  Instruction-fetch stage; producer of the IF/ID flow consumed by decode.

---
 rtl/if_fetch_stage.sv | 127 ++++++++++++
 tb/tb_if_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with single-outstanding imem handshake and IF/ID register.
// Define IF_PERF_CNT_EN to enable the perf_fetched / perf_bubbles counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, hold_instr_q, hold_instr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d, out_instr_q, out_instr_d;
    logic        load;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        load         = 1'b0;
        if (redirect) begin
            // a request still in flight must be drained before refetching
            state_d     = (state_q inside {WAIT, DRAIN}) && !imem_rvalid ? DRAIN : FETCH;
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                FETCH: if (!stall) begin
                    imem_req = 1'b1;
                    state_d  = WAIT;
                end
                WAIT: if (imem_rvalid && stall) begin
                    hold_instr_d = imem_rdata;
                    state_d      = HOLD;
                end else if (imem_rvalid) begin
                    load        = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = imem_rdata;
                    pc_d        = pc_q + 32'd4;
                    imem_req    = 1'b1;
                    imem_addr   = pc_q + 32'd4;
                end
                HOLD: if (!stall) begin
                    load        = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = hold_instr_q;
                    pc_d        = pc_q + 32'd4;
                    state_d     = FETCH;
                end
                DRAIN: if (imem_rvalid) state_d = FETCH;
            endcase
            if (load) out_valid_d = 1'b1;
            else if (!stall) begin
                out_valid_d = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end
        if (reset) imem_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= RESET_PC;
            out_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, load};
        perf_bubbles_d = perf_bubbles_q + {31'd0, !out_valid_q && !stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_bubbles = 32'd0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized and directed checks of if_fetch_stage against a
// transaction-level model (outstanding/stale/held flags) and a latency-configurable memory.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr, perf_fetched, perf_bubbles;

    if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr), .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int lat = 1;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_cnt = 0;
    logic        last_req;
    logic [31:0] last_addr;

    logic        m_busy, m_stale, m_held, m_out_v, m_pc_known;
    logic [31:0] m_pc, m_hi, m_out_pc, m_out_i, m_fetched, m_bubbles;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    // one clock cycle: drive, check the request against the model, advance memory, check IF/ID
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
        logic rv, e_req, ld;
        logic [31:0] rdat, e_addr;
        reset = r; stall = s; redirect = rd; redirect_pc = rp;
        rv = mem_busy && mem_cnt == 0;
        rdat = rv ? mem_word(mem_addr) : $urandom;
        imem_rvalid = rv; imem_rdata = rdat;
        #1;
        e_req = 1'b0; e_addr = m_pc; ld = 1'b0;
        if (!r && !m_out_v && !s) m_bubbles = m_bubbles + 1;
        if (r) begin
            m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_held = 0;
            m_out_v = 0; m_out_pc = RESET_PC; m_out_i = NOP_INSTR; m_pc_known = 1;
            m_fetched = 0; m_bubbles = 0;
        end else if (rd) begin
            m_pc = rp & ~32'd3; m_held = 0; m_out_v = 0; m_out_i = NOP_INSTR; m_pc_known = 0;
            m_stale = m_busy && !rv;
            m_busy = m_stale;
        end else if (m_stale) begin
            if (rv) begin m_stale = 0; m_busy = 0; end
            if (!s) begin m_out_v = 0; m_out_i = NOP_INSTR; end
        end else if (m_held) begin
            if (!s) begin
                ld = 1; m_out_pc = m_pc; m_out_i = m_hi; m_pc = m_pc + 4; m_held = 0;
            end
        end else if (m_busy) begin
            if (rv && s) begin
                m_held = 1; m_hi = rdat; m_busy = 0;
            end else if (rv) begin
                ld = 1; m_out_pc = m_pc; m_out_i = rdat; m_pc = m_pc + 4;
                e_req = 1; e_addr = m_pc;
            end else if (!s) begin
                m_out_v = 0; m_out_i = NOP_INSTR;
            end
        end else if (!s) begin
            e_req = 1; e_addr = m_pc; m_busy = 1; m_out_v = 0; m_out_i = NOP_INSTR;
        end
        if (ld) begin m_out_v = 1; m_pc_known = 1; m_fetched = m_fetched + 1; end
        n_cmp++;
        if (imem_req !== e_req) begin
            n_err++; $display("FAIL imem_req @%0t: got %b want %b", $time, imem_req, e_req);
        end
        if (e_req) begin
            n_cmp++;
            if (imem_addr !== e_addr) begin
                n_err++; $display("FAIL imem_addr @%0t: got %h want %h", $time, imem_addr, e_addr);
            end
        end
        last_req = imem_req; last_addr = imem_addr;
        if (r) mem_busy = 0;
        else begin
            if (rv) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req) begin
                mem_busy = 1; mem_addr = imem_addr;
                mem_cnt = (lat == 0 ? $urandom_range(1, 3) : lat) - 1;
            end
        end
        @(posedge clk); #1;
        n_cmp += 2;
        if (out_valid !== m_out_v) begin
            n_err++; $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_out_v);
        end
        if (out_instr !== m_out_i) begin
            n_err++; $display("FAIL out_instr @%0t: got %h want %h", $time, out_instr, m_out_i);
        end
        if (m_pc_known) begin
            n_cmp++;
            if (out_pc !== m_out_pc) begin
                n_err++; $display("FAIL out_pc @%0t: got %h want %h", $time, out_pc, m_out_pc);
            end
        end
        n_cmp += 2;
`ifdef IF_PERF_CNT_EN
        if (perf_fetched !== m_fetched) begin
            n_err++; $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, m_fetched);
        end
        if (perf_bubbles !== m_bubbles) begin
            n_err++; $display("FAIL perf_bubbles: got %0d want %0d", perf_bubbles, m_bubbles);
        end
`else
        if (perf_fetched !== 32'd0) begin
            n_err++; $display("FAIL perf_fetched: got %0d want 0", perf_fetched);
        end
        if (perf_bubbles !== 32'd0) begin
            n_err++; $display("FAIL perf_bubbles: got %0d want 0", perf_bubbles);
        end
`endif
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== RESET_PC || out_instr !== NOP_INSTR || last_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b pc=%h i=%h req=%b want v=0 pc=%h i=%h req=0",
                     out_valid, out_pc, out_instr, last_req, RESET_PC, NOP_INSTR);
        end
    endtask

    task automatic test_one_cycle_mem();
        lat = 1;
        step(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (last_req !== 1'b1 || last_addr !== 32'(4 * k)) begin
                n_err++; $display("FAIL seq_req k=%0d: got %b/%h want 1/%h", k, last_req, last_addr, 4 * k);
            end
            if (k >= 1) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1))) begin
                    n_err++; $display("FAIL seq_out k=%0d: got %b/%h want 1/%h", k, out_valid, out_pc, 4 * (k - 1));
                end
            end
        end
    endtask

    task automatic test_latency3();
        int nv = 0;
        lat = 3;
        step(1, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            step(0, 0, 0, 0);
            if (out_valid === 1'b1) nv++;
        end
        n_cmp++;
        if (nv != 4 || out_pc !== 32'hC) begin
            n_err++; $display("FAIL latency3: got %0d instrs last pc %h want 4 instrs last pc 0000000c", nv, out_pc);
        end
    endtask

    task automatic test_stall_hold();
        lat = 1;
        step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 || last_req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: got v=%b pc=%h req=%b want 1/00000004/0", out_valid, out_pc, last_req);
            end
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== mem_word(32'h8)) begin
            n_err++; $display("FAIL stall_release: got %b/%h/%h want 1/00000008/%h", out_valid, out_pc, out_instr, mem_word(32'h8));
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (last_req !== 1'b1 || last_addr !== 32'hC) begin
            n_err++; $display("FAIL stall_next_req: got %b/%h want 1/0000000c", last_req, last_addr);
        end
    endtask

    task automatic test_redirect_drain();
        lat = 3;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h103);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || last_req !== 1'b0) begin
            n_err++; $display("FAIL drain_stale: got v=%b req=%b want 0/0", out_valid, last_req);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (last_req !== 1'b1 || last_addr !== 32'h100) begin
            n_err++; $display("FAIL drain_refetch: got %b/%h want 1/00000100", last_req, last_addr);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            n_err++; $display("FAIL drain_out: got %b/%h want 1/00000100", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] rp;
        lat = 1;
        rp = $urandom;
        step(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
        step(0, 1, 1, rp);
        n_cmp++;
        if (out_valid !== 1'b0 || out_instr !== NOP_INSTR) begin
            n_err++; $display("FAIL redir_stall_out: got %b/%h want 0/%h", out_valid, out_instr, NOP_INSTR);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (last_req !== 1'b1 || last_addr !== {rp[31:2], 2'b00}) begin
            n_err++; $display("FAIL redir_stall_req: got %b/%h want 1/%h", last_req, last_addr, {rp[31:2], 2'b00});
        end
    endtask

    task automatic test_wrap();
        lat = 1;
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_cmp++;
        if (out_pc !== 32'hFFFF_FFFC || last_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_a: got pc=%h addr=%h want fffffffc/00000000", out_pc, last_addr);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            n_err++; $display("FAIL wrap_b: got %b/%h want 1/00000000", out_valid, out_pc);
        end
    endtask

    task automatic test_reset_mid_request();
        lat = 3;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || out_pc !== RESET_PC) begin
            n_err++; $display("FAIL reset_mid_out: got %b/%h want 0/%h", out_valid, out_pc, RESET_PC);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
            n_err++; $display("FAIL reset_mid_req: got %b/%h want 1/%h", last_req, last_addr, RESET_PC);
        end
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        lat = 0;
        step(1, 0, 0, 0);
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0, $urandom);
    endtask

    initial begin
        test_reset();
        test_one_cycle_mem();
        test_latency3();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
